variable_nodes_seq: RTL and testbench

//  Odd-layer (variable-node) update of the min-sum decoder; the counterpart of the check-node layer.
//  Per edge e (var v, chk c): v2c[e] = sat(llr[v] + sum over other edges e' of v of c2v[e']).

---
 rtl/variable_nodes_seq.sv | 131 +++++++++++++
 tb/tb_variable_nodes_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/variable_nodes_seq.sv
// variable_nodes_seq: variable-node (odd layer) update of the min-sum decoder.
// A serial edge walk first accumulates a full posterior per variable node
// (channel LLR plus every incoming c2v), then emits the extrinsic message
// v2c[e] = sat(sum[var(e)] - c2v[e]) one edge per cycle.
// Optional feature macro: VN_HARD_DEC_EN (posterior sign bits on hard_dec).
module variable_nodes_seq #(
    parameter int N_V = 44,
    parameter int N_C = 12,
    parameter int E   = 147,
    parameter int W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [E-1:0][1:0][7:0]    tanner_g,
    input  logic [N_V-1:0][W-1:0]     llr,
    input  logic [E-1:0][W-1:0]       c2v,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [E-1:0][W-1:0]       v2c,
    output logic [N_V-1:0]            hard_dec
);
    // Sum width leaves headroom for llr plus all E messages on one variable.
    localparam int SW = W + $clog2(E) + 1;
    localparam int CW = (E > 1) ? $clog2(E) : 1;
    localparam logic [CW-1:0] LAST = CW'(E - 1);
    localparam logic signed [SW:0] SAT_HI = (SW+1)'((1 << (W - 1)) - 1);
    localparam logic signed [SW:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic signed [SW-1:0]  sum [N_V];

    logic [7:0]            cur_v;
    logic                  cur_ok;
    logic signed [SW-1:0]  cur_sum;
    logic signed [SW-1:0]  cur_c2v;
    logic signed [SW:0]    diff;
    logic [W-1:0]          sat_val;

    // Check indices do not enter the arithmetic; fold them away explicitly.
    logic [E-1:0][7:0]     unused_chk_idx;
    logic                  unused_chk;

    // Check-node side of the edge map is carried only for interface symmetry.
    always_comb begin
        for (int e = 0; e < E; e++) unused_chk_idx[e] = tanner_g[e][1];
        unused_chk = (^unused_chk_idx) ^ (N_C < 1);
    end

    // Current edge: its variable's running sum, its c2v, and the saturated extrinsic.
    always_comb begin
        cur_v   = tanner_g[cnt][0];
        cur_c2v = {{(SW-W){c2v[cnt][W-1]}}, c2v[cnt]};
        cur_sum = '0;
        cur_ok  = 1'b0;
        for (int v = 0; v < N_V; v++) begin
            if (cur_v == 8'(v)) begin
                cur_sum = sum[v];
                cur_ok  = 1'b1;
            end
        end
        diff = {cur_sum[SW-1], cur_sum} - {cur_c2v[SW-1], cur_c2v};
        if (diff > SAT_HI)      sat_val = SAT_HI[W-1:0];
        else if (diff < SAT_LO) sat_val = SAT_LO[W-1:0];
        else                    sat_val = diff[W-1:0];
    end

    // Control FSM plus accumulate / emit datapath, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            v2c   <= '0;
            for (int v = 0; v < N_V; v++) sum[v] <= '0;
`ifdef VN_HARD_DEC_EN
            hard_dec <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int v = 0; v < N_V; v++)
                            sum[v] <= {{(SW-W){llr[v][W-1]}}, llr[v]};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    // Edges pointing past N_V match no variable and are skipped.
                    for (int v = 0; v < N_V; v++)
                        if (cur_v == 8'(v)) sum[v] <= sum[v] + cur_c2v;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= EMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    v2c[cnt] <= cur_ok ? sat_val : '0;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
`ifdef VN_HARD_DEC_EN
                    for (int v = 0; v < N_V; v++) hard_dec[v] <= sum[v][SW-1];
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef VN_HARD_DEC_EN
    assign hard_dec = '0;
`endif

endmodule

// File: tb/tb_variable_nodes_seq.sv
// Bench for variable_nodes_seq: a small instance (3 vars, 4 edges) for the
// directed scenarios and a full-size instance for randomised runs, both
// checked against a per-edge "sum over the other edges" reference.
module tb_variable_nodes_seq;
    localparam int W   = 8;
    localparam int SNV = 3,  SE = 4,   SNC = 2;
    localparam int BNV = 44, BE = 147, BNC = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic s_start = 1'b0, b_start = 1'b0;

    logic [SE-1:0][1:0][7:0] s_g;
    logic [SNV-1:0][W-1:0]   s_llr;
    logic [SE-1:0][W-1:0]    s_c2v, s_v2c;
    logic                    s_busy, s_done;
    logic [SNV-1:0]          s_hd;

    logic [BE-1:0][1:0][7:0] b_g;
    logic [BNV-1:0][W-1:0]   b_llr;
    logic [BE-1:0][W-1:0]    b_c2v, b_v2c;
    logic                    b_busy, b_done;
    logic [BNV-1:0]          b_hd;

    int m_g   [BE];
    int m_llr [BNV];
    int m_c2v [BE];

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;
    int m_k = -1;

    variable_nodes_seq #(.N_V(SNV), .N_C(SNC), .E(SE), .W(W)) u_small (
        .clk(clk), .rst(rst), .tanner_g(s_g), .llr(s_llr), .c2v(s_c2v),
        .start(s_start), .busy(s_busy), .done(s_done), .v2c(s_v2c), .hard_dec(s_hd));

    variable_nodes_seq #(.N_V(BNV), .N_C(BNC), .E(BE), .W(W)) u_big (
        .clk(clk), .rst(rst), .tanner_g(b_g), .llr(b_llr), .c2v(b_c2v),
        .start(b_start), .busy(b_busy), .done(b_done), .v2c(b_v2c), .hard_dec(b_hd));

    always_comb begin
        for (int e = 0; e < SE; e++) begin
            s_g[e][0] = 8'(m_g[e]);
            s_g[e][1] = 8'(e / 2);
            s_c2v[e]  = W'(m_c2v[e]);
        end
        for (int v = 0; v < SNV; v++) s_llr[v] = W'(m_llr[v]);
        for (int e = 0; e < BE; e++) begin
            b_g[e][0] = 8'(m_g[e]);
            b_g[e][1] = 8'(e % BNC);
            b_c2v[e]  = W'(m_c2v[e]);
        end
        for (int v = 0; v < BNV; v++) b_llr[v] = W'(m_llr[v]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 127)  return 127;
        if (x < -127) return -127;
        return x;
    endfunction

    // Extrinsic message straight from the definition: llr plus the other edges of v.
    function automatic int ref_v2c(input int nv, input int ne, input int e);
        int v, acc;
        v = m_g[e];
        if (v >= nv) return 0;
        acc = m_llr[v];
        for (int k = 0; k < ne; k++)
            if (k != e && m_g[k] == v) acc += m_c2v[k];
        return sat(acc);
    endfunction

    function automatic int ref_hd(input int ne, input int v);
`ifdef VN_HARD_DEC_EN
        int acc;
        acc = m_llr[v];
        for (int k = 0; k < ne; k++)
            if (m_g[k] == v) acc += m_c2v[k];
        return (acc < 0) ? 1 : 0;
`else
        return (ne < 0 && v < 0) ? 1 : 0;
`endif
    endfunction

    // Small-instance timing model: edges elapsed since an accepted start.
    always @(posedge clk) begin
        if (rst) m_k = -1;
        else if (s_start && (m_k < 0 || m_k >= 2*SE+1)) m_k = 0;
        else if (m_k >= 0) begin
            m_k++;
            if (m_k > 2*SE+1) m_k = -1;
        end
    end

    // Per-cycle compare of the small instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_busy", int'(s_busy), (m_k >= 0 && m_k <= 2*SE-1) ? 1 : 0);
            chk("s_done", int'(s_done), (m_k == 2*SE+1) ? 1 : 0);
            if (m_k == 2*SE+1) begin
                for (int e = 0; e < SE; e++)
                    chk($sformatf("s_v2c[%0d]", e), int'($signed(s_v2c[e])), ref_v2c(SNV, SE, e));
                for (int v = 0; v < SNV; v++)
                    chk($sformatf("s_hd[%0d]", v), int'(s_hd[v]), ref_hd(SE, v));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_s();
        s_start = 1'b1; tick(); s_start = 1'b0;
    endtask

    task automatic wait_done_s(output int cyc);
        cyc = 0;
        while (!s_done && cyc < 100) begin tick(); cyc++; end
    endtask

    task automatic set_small(input int l0, l1, l2, c0, c1, c2, c3);
        m_g[0] = 0; m_g[1] = 1; m_g[2] = 1; m_g[3] = 2;
        m_llr[0] = l0; m_llr[1] = l1; m_llr[2] = l2;
        m_c2v[0] = c0; m_c2v[1] = c1; m_c2v[2] = c2; m_c2v[3] = c3;
    endtask

    task automatic lit_v2c(input string nm, input int a, b, c, d);
        chk({nm, "_v2c0"}, int'($signed(s_v2c[0])), a);
        chk({nm, "_v2c1"}, int'($signed(s_v2c[1])), b);
        chk({nm, "_v2c2"}, int'($signed(s_v2c[2])), c);
        chk({nm, "_v2c3"}, int'($signed(s_v2c[3])), d);
    endtask

    task automatic lit_hd(input string nm, input int h0, h1, h2);
`ifdef VN_HARD_DEC_EN
        chk({nm, "_hd"}, int'(s_hd), h0 | (h1 << 1) | (h2 << 2));
`else
        chk({nm, "_hd"}, int'(s_hd), (h0 + h1 + h2) * 0);
`endif
    endtask

    task automatic run_big(input string nm);
        int cyc;
        b_start = 1'b1; tick(); b_start = 1'b0;
        cyc = 0;
        while (!b_done && cyc < 400) begin tick(); cyc++; end
        chk({nm, "_latency"}, cyc, 2*BE+1);
        for (int e = 0; e < BE; e++)
            chk($sformatf("%s_v2c[%0d]", nm, e), int'($signed(b_v2c[e])), ref_v2c(BNV, BE, e));
        for (int v = 0; v < BNV; v++)
            chk($sformatf("%s_hd[%0d]", nm, v), int'(b_hd[v]), ref_hd(BE, v));
        tick();
        chk({nm, "_done_pulse"}, int'(b_done), 0);
    endtask

    initial begin
        int cyc, busy_cnt, done_cnt;
        for (int e = 0; e < BE; e++) begin m_g[e] = 0; m_c2v[e] = 0; end
        for (int v = 0; v < BNV; v++) m_llr[v] = 0;
        set_small(10, -5, 3, 2, 4, -6, 1);

        // Reset state, with start asserted alongside reset.
        rst = 1'b1; s_start = 1'b1; tick(); tick(); s_start = 1'b0; rst = 1'b0;
        chk_en = 1;
        chk("rst_v2c", int'(s_v2c), 0);
        chk("rst_hd", int'(s_hd), 0);
        chk("rst_busy", int'(s_busy), 0);
        tick();
        chk("rst_no_start", int'(s_busy), 0);

        // 1. Basic.
        pulse_s(); wait_done_s(cyc);
        chk("basic_latency", cyc, 9);
        lit_v2c("basic", 10, -11, -1, 3);
        lit_hd("basic", 0, 1, 0);

        // 5. Back-to-back: start in the cycle after done with zeroed c2v.
        @(negedge clk); #1;
        m_c2v[0] = 0; m_c2v[1] = 0; m_c2v[2] = 0; m_c2v[3] = 0;
        s_start = 1'b1; tick(); s_start = 1'b0;
        wait_done_s(cyc);
        chk("b2b_latency", cyc, 9);
        lit_v2c("b2b", 10, -5, -5, 3);
        lit_hd("b2b", 0, 1, 0);
        tick();

        // 2. Saturation.
        set_small(-128, 100, 0, 5, 100, 50, 0);
        pulse_s(); wait_done_s(cyc);
        chk("sat_latency", cyc, 9);
        lit_v2c("sat", -127, 127, 127, 0);
        lit_hd("sat", 1, 0, 0);
        tick();

        // 3. Busy handling: extra starts at edges 1 and 5 are dropped.
        set_small(10, -5, 3, 2, 4, -6, 1);
        pulse_s();
        busy_cnt = int'(s_busy); done_cnt = int'(s_done);
        for (int k = 1; k <= 20; k++) begin
            s_start = (k == 1 || k == 5);
            tick();
            s_start = 1'b0;
            busy_cnt += int'(s_busy);
            done_cnt += int'(s_done);
        end
        chk("busy_cycles", busy_cnt, 8);
        chk("done_count", done_cnt, 1);

        // 4. Reset during the second EMIT cycle.
        set_small(-128, 100, 0, 5, 100, 50, 0);
        pulse_s();
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_v2c", int'(s_v2c), 0);
        chk("midrst_hd", int'(s_hd), 0);
        chk("midrst_busy", int'(s_busy), 0);
        chk("midrst_done", int'(s_done), 0);
        repeat (12) tick();
        chk("midrst_idle", int'(s_busy), 0);
        set_small(10, -5, 3, 2, 4, -6, 1);
        pulse_s(); wait_done_s(cyc);
        chk("rerun_latency", cyc, 9);
        lit_v2c("rerun", 10, -11, -1, 3);
        tick();

        // 6. Randomised full-size runs; var 43 has no edges, a few edges point past N_V.
        for (int r = 0; r < 3; r++) begin
            for (int e = 0; e < BE; e++) begin
                m_g[e] = $urandom_range(0, BNV - 2);
                m_c2v[e] = (r == 2) ? ((e % 2) ? 127 : -128) : ($urandom_range(0, 255) - 128);
            end
            m_g[7] = 50; m_g[90] = 255;
            for (int v = 0; v < BNV; v++) m_llr[v] = $urandom_range(0, 255) - 128;
            m_llr[BNV-1] = -20;
            run_big($sformatf("rand%0d", r));
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
